// File: rtl/count_mux_sequencer_pkg.sv
// Shared definitions for the counter / AND-XOR mux sequencer: the FSM state
// encoding, the mux mode codes and the counter width.
package count_mux_sequencer_pkg;

    localparam int CNT_W = 3;

    localparam logic MODE_AND = 1'b0;
    localparam logic MODE_XOR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage : count_mux_sequencer_pkg

// File: rtl/count_mux_sequencer_cnt_step_unit.sv
// One datapath step: advances the 3-bit counter (wrapping 7 -> 0) and
// produces the mux result bit for the current count (c0&c2 or c0^c2).
module cnt_step_unit
    import count_mux_sequencer_pkg::*;
(
    input  logic [CNT_W-1:0] count,
    input  logic             mode,
    output logic [CNT_W-1:0] next_count,
    output logic             step_bit
);

    // Next count and mux bit from the current count.
    always_comb begin
        // NOTE: every output gets a value on every path through this block, so no latch is inferred.
        next_count = count + CNT_W'(1);
        step_bit   = 1'b0;
        if (mode == MODE_XOR) begin
            step_bit = count[0] ^ count[2];
        end else begin
            step_bit = count[0] & count[2];
        end
    end

endmodule : cnt_step_unit

// File: rtl/count_mux_sequencer.sv
// Command-driven controller for the counter / mux datapath. A command
// {mode, seed, len} loads the counter, runs len steps shifting one mux bit
// per step into a result register, then presents the packed bits and the
// final count on a valid/ready response channel. One command in flight.
module count_mux_sequencer
    import count_mux_sequencer_pkg::*;
#(
    parameter int LEN_W = 4,
    parameter int RES_W = 8
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [CNT_W-1:0] cmd_seed,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_data,
    output logic [CNT_W-1:0] rsp_count,
    output logic             busy
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [LEN_W-1:0] remaining;
    logic [RES_W-1:0] shreg;
    logic             mode;

    logic [CNT_W-1:0] next_count;
    logic             step_bit;
    logic [RES_W-1:0] shreg_next;

    cnt_step_unit u_step (
        .count      (count),
        .mode       (mode),
        .next_count (next_count),
        .step_bit   (step_bit)
    );

    // Newest step bit enters at the LSB; bits older than RES_W steps fall off the top.
    assign shreg_next = {shreg[RES_W-2:0], step_bit};

    // Sequencer FSM with registered handshake outputs. The response registers are
    // loaded only on entry to DONE so they stay put while the next command runs.
    always_ff @(posedge clk) begin
        // NOTE: all state here is updated with non-blocking assignments so every
        // register sees the pre-edge values of the others, regardless of statement order.
        if (res) begin
            state     <= ST_IDLE;
            count     <= '0;
            remaining <= '0;
            shreg     <= '0;
            mode      <= MODE_AND;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_count <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        count     <= cmd_seed;
                        remaining <= cmd_len;
                        mode      <= cmd_mode;
                        shreg     <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            // Zero-length command: respond with the seed and an empty result.
                            state     <= ST_DONE;
                            rsp_valid <= 1'b1;
                            rsp_data  <= '0;
                            rsp_count <= cmd_seed;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    shreg     <= shreg_next;
                    count     <= next_count;
                    remaining <= remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state     <= ST_DONE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= shreg_next;
                        rsp_count <= next_count;
                    end
                end

                ST_DONE: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule : count_mux_sequencer

// File: tb/tb_count_mux_sequencer.sv
// Scoreboard bench for count_mux_sequencer: the driver pushes the expected
// response of each accepted command; a negedge monitor pops it when rsp_valid
// rises and checks data, count, latency and stability while it is held.
module tb_count_mux_sequencer;

    localparam int LEN_W = 4;
    localparam int RES_W = 8;

    logic             clk = 1'b0;
    logic             res;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_mode;
    logic [2:0]       cmd_seed;
    logic [LEN_W-1:0] cmd_len;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [RES_W-1:0] rsp_data;
    logic [2:0]       rsp_count;
    logic             busy;

    count_mux_sequencer #(.LEN_W(LEN_W), .RES_W(RES_W)) dut (
        .clk       (clk),
        .res       (res),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_seed  (cmd_seed),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_count (rsp_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k has settled, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RES_W-1:0] data;
        logic [2:0]       count;
        int               acc;
        int               len;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    bit   cur_ok = 1'b0;
    bit   in_rsp = 1'b0;
    int   n_vec  = 0;
    int   n_err  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop on the first cycle of each response, then check it holds steady.
    always @(negedge clk) begin
        if (res !== 1'b1 && rsp_valid === 1'b1) begin
            if (!in_rsp) begin
                in_rsp = 1'b1;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    cur_ok = 1'b0;
                    $display("FAIL unexpected_rsp: rsp_valid=1 with nothing outstanding, expected none (t=%0t)", $time);
                end else begin
                    cur    = sb.pop_front();
                    cur_ok = 1'b1;
                    check("rsp_latency", cyc - cur.acc, cur.len);
                    check("rsp_data",    rsp_data,      cur.data);
                    check("rsp_count",   rsp_count,     cur.count);
                end
            end else if (cur_ok) begin
                check("rsp_data_stable",  rsp_data,  cur.data);
                check("rsp_count_stable", rsp_count, cur.count);
            end
        end else begin
            in_rsp = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a command until accepted; optionally queue its expected response.
    task automatic send(input logic m, input logic [2:0] s, input logic [LEN_W-1:0] l,
                        input logic [RES_W-1:0] ed, input logic [2:0] ec, input bit exp_rsp);
        int n;
        exp_t e;
        n         = 0;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_seed  = s;
        cmd_len   = l;
        while (cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            check("cmd_ready_timeout", 32'(cmd_ready), 1);
            cmd_valid = 1'b0;
            return;
        end
        tick();
        if (exp_rsp) begin
            e.data  = ed;
            e.count = ec;
            e.acc   = cyc;
            e.len   = int'(l);
            sb.push_back(e);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
            tick();
            n++;
        end
        check("drain_done", 32'(n < 200), 1);
    endtask

    initial begin
        // T1: reset held two cycles with a command offered.
        res       = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = 1'b1;
        cmd_seed  = 3'd3;
        cmd_len   = 4'd4;
        rsp_ready = 1'b1;
        tick();
        tick();
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_busy",      32'(busy),      0);
        check("rst_rsp_data",  32'(rsp_data),  0);
        check("rst_rsp_count", 32'(rsp_count), 0);
        res       = 1'b0;
        cmd_valid = 1'b0;
        tick();
        check("post_rst_busy",      32'(busy),      0);
        check("post_rst_cmd_ready", 32'(cmd_ready), 1);

        // T2: AND, seed 0, len 8.
        send(1'b0, 3'd0, 4'd8, 8'h05, 3'd0, 1'b1);
        wait_drain();

        // T3: XOR patterns.
        send(1'b1, 3'd0, 4'd8, 8'h5A, 3'd0, 1'b1);
        wait_drain();
        send(1'b1, 3'd6, 4'd3, 8'h04, 3'd1, 1'b1);
        wait_drain();

        // T4: zero length and overflow truncation.
        send(1'b1, 3'd5, 4'd0, 8'h00, 3'd5, 1'b1);
        wait_drain();
        send(1'b1, 3'd0, 4'd15, 8'h2D, 3'd7, 1'b1);
        wait_drain();

        // T5: backpressure in DONE with stray command pulses.
        rsp_ready = 1'b0;
        send(1'b0, 3'd0, 4'd8, 8'h05, 3'd0, 1'b1);
        begin
            int n;
            n = 0;
            while (rsp_valid !== 1'b1 && n < 50) begin
                tick();
                n++;
            end
            check("bp_rsp_valid_seen", 32'(rsp_valid), 1);
        end
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i % 2 == 0);
            cmd_mode  = 1'b1;
            cmd_seed  = 3'd3;
            cmd_len   = 4'd2;
            tick();
            check("bp_cmd_ready", 32'(cmd_ready), 0);
            check("bp_busy",      32'(busy),      1);
            check("bp_rsp_valid", 32'(rsp_valid), 1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        check("bp_idle_cmd_ready", 32'(cmd_ready), 1);
        check("bp_idle_rsp_valid", 32'(rsp_valid), 0);
        check("bp_idle_busy",      32'(busy),      0);
        send(1'b1, 3'd6, 4'd3, 8'h04, 3'd1, 1'b1);
        wait_drain();

        // T6: reset on the third RUN cycle aborts without a response.
        send(1'b0, 3'd0, 4'd8, 8'h00, 3'd0, 1'b0);
        tick();
        tick();
        res = 1'b1;
        tick();
        res = 1'b0;
        check("abort_busy",      32'(busy),      0);
        check("abort_cmd_ready", 32'(cmd_ready), 1);
        check("abort_rsp_valid", 32'(rsp_valid), 0);
        for (int i = 0; i < 12; i++) tick();
        check("abort_no_rsp_busy", 32'(busy), 0);
        send(1'b1, 3'd0, 4'd8, 8'h5A, 3'd0, 1'b1);
        wait_drain();
        check("sb_empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_count_mux_sequencer
